// File: rtl/ssd_row_feeder.sv
// rtl/ssd_row_feeder.sv - packs paired pixel streams into row words and sequences one MAC window per start.
// Optional flush_in port is enabled by defining SSD_FEEDER_FLUSH_EN.
module ssd_row_feeder #(
  parameter int PIXEL_WIDTH = 8,
  parameter int ROW_PIXELS  = 6,
  parameter int WINDOW_ROWS = 6
) (
  input  logic                              clk_in,
  input  logic                              rst_n_in,
  input  logic                              start_in,
  input  logic                              pixel_valid_in,
  output logic                              pixel_ready_out,
  input  logic [PIXEL_WIDTH-1:0]            left_pixel_in,
  input  logic [PIXEL_WIDTH-1:0]            right_pixel_in,
`ifdef SSD_FEEDER_FLUSH_EN
  input  logic                              flush_in,
`endif
  output logic [PIXEL_WIDTH*ROW_PIXELS-1:0] left_row_out,
  output logic [PIXEL_WIDTH*ROW_PIXELS-1:0] right_row_out,
  output logic                              row_valid_out,
  output logic                              mac_clear_out,
  output logic                              window_done_out,
  output logic                              busy_out
);

  localparam int ROW_W = PIXEL_WIDTH * ROW_PIXELS;
  localparam int PCW   = $clog2(ROW_PIXELS + 1);
  localparam int RCW   = $clog2(WINDOW_ROWS + 1);
  localparam logic [PCW-1:0] LAST_PIX = PCW'(ROW_PIXELS - 1);
  localparam logic [RCW-1:0] LAST_ROW = RCW'(WINDOW_ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_PACK,
    S_EMIT,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [PCW-1:0]     pix_cnt_q, pix_cnt_d;
  logic [RCW-1:0]     row_cnt_q, row_cnt_d;
  logic [ROW_W-1:0]   left_buf_q, left_buf_d;
  logic [ROW_W-1:0]   right_buf_q, right_buf_d;
  logic [ROW_W-1:0]   left_row_q, left_row_d;
  logic [ROW_W-1:0]   right_row_q, right_row_d;
  logic [ROW_W-1:0]   left_merged, right_merged;
  logic               hs;
  logic               flush_req;

  always_comb begin
    state_d     = state_q;
    pix_cnt_d   = pix_cnt_q;
    row_cnt_d   = row_cnt_q;
    left_buf_d  = left_buf_q;
    right_buf_d = right_buf_q;
    left_row_d  = left_row_q;
    right_row_d = right_row_q;
    flush_req   = 1'b0;
`ifdef SSD_FEEDER_FLUSH_EN
    flush_req   = flush_in;
`endif
    hs           = (state_q == S_PACK) && pixel_valid_in;
    left_merged  = left_buf_q;
    right_merged = right_buf_q;
    // Buffers are cleared at each row load, so unfilled slots are already zero on a flush.
    for (int k = 0; k < ROW_PIXELS; k++) begin
      if (hs && (pix_cnt_q == PCW'(k))) begin
        left_merged[k*PIXEL_WIDTH +: PIXEL_WIDTH]  = left_pixel_in;
        right_merged[k*PIXEL_WIDTH +: PIXEL_WIDTH] = right_pixel_in;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start_in) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        row_cnt_d   = '0;
        pix_cnt_d   = '0;
        left_buf_d  = '0;
        right_buf_d = '0;
        state_d     = S_PACK;
      end
      S_PACK: begin
        if ((hs && (pix_cnt_q == LAST_PIX)) || (flush_req && (hs || (pix_cnt_q != '0)))) begin
          left_row_d  = left_merged;
          right_row_d = right_merged;
          left_buf_d  = '0;
          right_buf_d = '0;
          pix_cnt_d   = '0;
          if (flush_req) row_cnt_d = LAST_ROW;
          state_d     = S_EMIT;
        end else if (flush_req) begin
          state_d = S_DONE;
        end else if (hs) begin
          left_buf_d  = left_merged;
          right_buf_d = right_merged;
          pix_cnt_d   = pix_cnt_q + 1'b1;
        end
      end
      S_EMIT: begin
        row_cnt_d = row_cnt_q + 1'b1;
        state_d   = (row_cnt_q == LAST_ROW) ? S_DONE : S_PACK;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= S_IDLE;
      pix_cnt_q   <= '0;
      row_cnt_q   <= '0;
      left_buf_q  <= '0;
      right_buf_q <= '0;
      left_row_q  <= '0;
      right_row_q <= '0;
    end else begin
      state_q     <= state_d;
      pix_cnt_q   <= pix_cnt_d;
      row_cnt_q   <= row_cnt_d;
      left_buf_q  <= left_buf_d;
      right_buf_q <= right_buf_d;
      left_row_q  <= left_row_d;
      right_row_q <= right_row_d;
    end
  end

  assign pixel_ready_out = (state_q == S_PACK);
  assign mac_clear_out   = (state_q == S_CLEAR);
  assign row_valid_out   = (state_q == S_EMIT);
  assign window_done_out = (state_q == S_DONE);
  assign busy_out        = (state_q != S_IDLE);
  assign left_row_out    = left_row_q;
  assign right_row_out   = right_row_q;

endmodule
